// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among functional units with a
// one-cycle registered broadcast of the winning result packet.
package cdb_pkg;
  typedef struct packed {
    logic [3:0]  dest_ROB_entry;
    logic [31:0] result;
    logic        branch_result;
    logic        from_memory;
  } CDB_packet_t;
endpackage

module cdb_arbiter #(
  parameter int NUM_FU = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_FU-1:0]                    fu_valid,
  input  cdb_pkg::CDB_packet_t [NUM_FU-1:0]    fu_packet,
  input  logic                                 cdb_stall,
  input  logic                                 flush,
  output logic [NUM_FU-1:0]                    fu_yumi,
  output logic                                 cdb_valid,
  output cdb_pkg::CDB_packet_t                 cdb
);

  localparam int PTR_W = $clog2(NUM_FU);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] rr_ptr_nxt;
  logic             grant_any;

  // Grant stage: search starts at rr_ptr and wraps modulo NUM_FU
  always_comb begin
    int idx;
    fu_yumi   = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    if (!(reset || flush || cdb_stall)) begin
      for (int k = 0; k < NUM_FU; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_FU) idx = idx - NUM_FU;
        if (!grant_any && fu_valid[idx]) begin
          grant_any = 1'b1;
          grant_idx = PTR_W'(idx);
        end
      end
    end
    if (grant_any) fu_yumi[grant_idx] = 1'b1;
  end

  // Explicit wrap so non-power-of-two NUM_FU never lands on an unused index
  always_comb begin
    if (grant_idx == PTR_W'(NUM_FU - 1)) rr_ptr_nxt = '0;
    else                                  rr_ptr_nxt = grant_idx + 1'b1;
  end

  // Broadcast stage: cdb holds its last packet when nothing is granted
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb       <= '0;
    end else begin
      cdb_valid <= grant_any;
      if (grant_any) begin
        cdb    <= fu_packet[grant_idx];
        rr_ptr <= rr_ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (NUM_FU = 4): reset, single request,
// fairness, wrap, stall, flush and mid-stream reset.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic                    clk;
  logic                    reset;
  logic [3:0]              fu_valid;
  CDB_packet_t [3:0]       fu_packet;
  logic                    cdb_stall;
  logic                    flush;
  logic [3:0]              fu_yumi;
  logic                    cdb_valid;
  CDB_packet_t             cdb;

  int pass_cnt = 0;
  int total_cnt = 0;

  cdb_arbiter #(.NUM_FU(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .fu_valid  (fu_valid),
    .fu_packet (fu_packet),
    .cdb_stall (cdb_stall),
    .flush     (flush),
    .fu_yumi   (fu_yumi),
    .cdb_valid (cdb_valid),
    .cdb       (cdb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are changed 1ns after it, checks 2ns after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; fu_valid = 4'b1111;
    #2;
    total_cnt++;
    if (fu_yumi !== 4'b0000) $display("FAIL reset_yumi: got %b want 0000", fu_yumi); else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if (cdb_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", cdb_valid); else pass_cnt++;
    total_cnt++;
    if (cdb !== 38'd0) $display("FAIL reset_cdb: got %h want 0", cdb); else pass_cnt++;
    fu_valid = 4'b0000;
    reset = 1'b0;
  endtask

  task automatic test_single();
    fu_packet[2] = '{dest_ROB_entry: 4'd5, result: 32'hDEADBEEF, branch_result: 1'b0, from_memory: 1'b0};
    fu_valid = 4'b0100;
    #2;
    total_cnt++;
    if (fu_yumi !== 4'b0100) $display("FAIL single_yumi: got %b want 0100", fu_yumi); else pass_cnt++;
    tick();
    fu_valid = 4'b0000;
    #1;
    total_cnt++;
    if (cdb_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", cdb_valid); else pass_cnt++;
    total_cnt++;
    if (cdb.dest_ROB_entry !== 4'd5) $display("FAIL single_rob: got %0d want 5", cdb.dest_ROB_entry); else pass_cnt++;
    total_cnt++;
    if (cdb.result !== 32'hDEADBEEF) $display("FAIL single_result: got %h want deadbeef", cdb.result); else pass_cnt++;
    tick();
    total_cnt++;
    if (cdb_valid !== 1'b0) $display("FAIL single_valid_drop: got %b want 0", cdb_valid); else pass_cnt++;
    total_cnt++;
    if (cdb.dest_ROB_entry !== 4'd5) $display("FAIL single_hold: got %0d want 5", cdb.dest_ROB_entry); else pass_cnt++;
  endtask

  task automatic test_fairness();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++)
      fu_packet[i] = '{dest_ROB_entry: 4'(i), result: 32'h1000 + 32'(i), branch_result: 1'b0, from_memory: 1'b1};
    fu_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      total_cnt++;
      if (fu_yumi !== 4'(1 << (c % 4))) $display("FAIL fair_yumi_%0d: got %b want %b", c, fu_yumi, 4'(1 << (c % 4)));
      else pass_cnt++;
      tick();
      total_cnt++;
      if (cdb_valid !== 1'b1 || cdb.dest_ROB_entry !== 4'(c % 4) || cdb.result !== 32'h1000 + 32'(c % 4))
        $display("FAIL fair_cdb_%0d: got v=%b rob=%0d res=%h want v=1 rob=%0d", c, cdb_valid, cdb.dest_ROB_entry, cdb.result, c % 4);
      else pass_cnt++;
    end
    fu_valid = 4'b0000;
    tick();
    total_cnt++;
    if (cdb_valid !== 1'b0) $display("FAIL fair_idle: got %b want 0", cdb_valid); else pass_cnt++;
  endtask

  task automatic test_wrap();
    // rr_ptr is 0 here; a grant to index 2 moves it to 3
    fu_valid = 4'b0100;
    tick();
    fu_valid = 4'b0011;
    #1;
    total_cnt++;
    if (fu_yumi !== 4'b0001) $display("FAIL wrap_yumi0: got %b want 0001", fu_yumi); else pass_cnt++;
    tick();
    total_cnt++;
    if (cdb_valid !== 1'b1 || cdb.dest_ROB_entry !== 4'd0) $display("FAIL wrap_cdb0: got v=%b rob=%0d want v=1 rob=0", cdb_valid, cdb.dest_ROB_entry); else pass_cnt++;
    total_cnt++;
    if (fu_yumi !== 4'b0010) $display("FAIL wrap_yumi1: got %b want 0010", fu_yumi); else pass_cnt++;
    tick();
    fu_valid = 4'b0000;
    #1;
    total_cnt++;
    if (cdb_valid !== 1'b1 || cdb.dest_ROB_entry !== 4'd1) $display("FAIL wrap_cdb1: got v=%b rob=%0d want v=1 rob=1", cdb_valid, cdb.dest_ROB_entry); else pass_cnt++;
  endtask

  task automatic test_stall();
    // rr_ptr is 2 here
    tick();
    fu_valid = 4'b0010; cdb_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total_cnt++;
      if (fu_yumi !== 4'b0000) $display("FAIL stall_yumi_%0d: got %b want 0000", c, fu_yumi); else pass_cnt++;
      tick();
      total_cnt++;
      if (cdb_valid !== 1'b0) $display("FAIL stall_valid_%0d: got %b want 0", c, cdb_valid); else pass_cnt++;
    end
    cdb_stall = 1'b0;
    #1;
    total_cnt++;
    if (fu_yumi !== 4'b0010) $display("FAIL stall_release_yumi: got %b want 0010", fu_yumi); else pass_cnt++;
    tick();
    fu_valid = 4'b1011;
    #1;
    total_cnt++;
    if (cdb_valid !== 1'b1 || cdb.dest_ROB_entry !== 4'd1) $display("FAIL stall_cdb: got v=%b rob=%0d want v=1 rob=1", cdb_valid, cdb.dest_ROB_entry); else pass_cnt++;
    total_cnt++;
    if (fu_yumi !== 4'b1000) $display("FAIL stall_ptr_kept: got %b want 1000", fu_yumi); else pass_cnt++;
    tick();
    fu_valid = 4'b0000;
  endtask

  task automatic test_flush();
    // rr_ptr is 0 here; cdb holds FU 3's packet
    fu_valid = 4'b0001; flush = 1'b1;
    #1;
    total_cnt++;
    if (fu_yumi !== 4'b0000) $display("FAIL flush_yumi: got %b want 0000", fu_yumi); else pass_cnt++;
    tick();
    total_cnt++;
    if (cdb_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", cdb_valid); else pass_cnt++;
    total_cnt++;
    if (cdb.dest_ROB_entry !== 4'd3) $display("FAIL flush_hold: got %0d want 3", cdb.dest_ROB_entry); else pass_cnt++;
    cdb_stall = 1'b1;
    #1;
    total_cnt++;
    if (fu_yumi !== 4'b0000) $display("FAIL flush_stall_yumi: got %b want 0000", fu_yumi); else pass_cnt++;
    tick();
    flush = 1'b0; cdb_stall = 1'b0;
    #1;
    total_cnt++;
    if (fu_yumi !== 4'b0001) $display("FAIL flush_after_yumi: got %b want 0001", fu_yumi); else pass_cnt++;
    tick();
    fu_valid = 4'b0000;
    #1;
    total_cnt++;
    if (cdb_valid !== 1'b1 || cdb.dest_ROB_entry !== 4'd0) $display("FAIL flush_after_cdb: got v=%b rob=%0d want v=1 rob=0", cdb_valid, cdb.dest_ROB_entry); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    // cdb_valid is 1 and rr_ptr is 1 here
    fu_valid = 4'b1001; reset = 1'b1;
    #1;
    total_cnt++;
    if (fu_yumi !== 4'b0000) $display("FAIL rmid_yumi: got %b want 0000", fu_yumi); else pass_cnt++;
    tick();
    reset = 1'b0;
    #1;
    total_cnt++;
    if (cdb_valid !== 1'b0 || cdb !== 38'd0) $display("FAIL rmid_cleared: got v=%b cdb=%h want v=0 cdb=0", cdb_valid, cdb); else pass_cnt++;
    total_cnt++;
    if (fu_yumi !== 4'b0001) $display("FAIL rmid_first: got %b want 0001", fu_yumi); else pass_cnt++;
    tick();
    total_cnt++;
    if (fu_yumi !== 4'b1000) $display("FAIL rmid_second: got %b want 1000", fu_yumi); else pass_cnt++;
    tick();
    fu_valid = 4'b0000;
    #1;
    total_cnt++;
    if (cdb_valid !== 1'b1 || cdb.dest_ROB_entry !== 4'd3) $display("FAIL rmid_cdb: got v=%b rob=%0d want v=1 rob=3", cdb_valid, cdb.dest_ROB_entry); else pass_cnt++;
  endtask

  task automatic test_drop();
    fu_valid = 4'b0100;
    #1;
    fu_valid = 4'b0000;
    #1;
    total_cnt++;
    if (fu_yumi !== 4'b0000) $display("FAIL drop_yumi: got %b want 0000", fu_yumi); else pass_cnt++;
    tick();
    total_cnt++;
    if (cdb_valid !== 1'b0) $display("FAIL drop_valid: got %b want 0", cdb_valid); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; fu_valid = '0; fu_packet = '0; cdb_stall = 1'b0; flush = 1'b0;
    tick();
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_stall();
    test_flush();
    test_reset_mid();
    test_drop();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
